fft_ctrl: RTL and testbench

Sequencer for the radix-2 in-place FFT datapath. It walks all M stages × N/2 butterflies and generates the outputs below:
- read addresses for the source RAM bank;
- twiddle ROM addresses;
- delayed write addresses and the write enable for the destination bank;
- the ping-pong bank select.

It sits between the top-level capture logic, which fills RAM0 and pulses `start`, and the two `dual_RAM` banks, the `twiddle_ROM` and the butterfly pipeline.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_adr_delay.sv | 32 +++
 rtl/fft_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fft_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT sequencer: default geometry, state
// encoding and the address rotate helper used by the controller and its bench.
package fft_pkg;

  localparam int unsigned M_DEF   = 9;
  localparam int unsigned N_DEF   = 2 ** M_DEF;
  localparam int unsigned LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  // Rotate the low w bits of x left by s (0 <= s < w < 32); upper bits return 0.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned w,
                                       input int unsigned s);
    logic [31:0] mask;
    logic [31:0] xm;
    mask = (32'(1) << w) - 32'(1);
    xm   = x & mask;
    return ((xm << s) | (xm >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/fft_adr_delay.sv
// LAT-deep shift register carrying {valid, adr_a, adr_b} from the read side to
// the write side of the butterfly pipeline.
module fft_adr_delay #(
  parameter int unsigned LAT = 3,
  parameter int unsigned AW  = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_vld,
  input  logic [AW-1:0] d_a,
  input  logic [AW-1:0] d_b,
  output logic          q_vld,
  output logic [AW-1:0] q_a,
  output logic [AW-1:0] q_b
);

  localparam int unsigned DW = 2 * AW + 1;

  logic [DW-1:0] pipe [LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {d_vld, d_a, d_b};
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {q_vld, q_a, q_b} = pipe[LAT-1];

endmodule

// File: rtl/fft_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 FFT (constant-geometry
// rotate addressing, ping-pong banks). FFT_CTRL_CYCLES_EN adds a run-length counter.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned M   = M_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         rd_bank,
  output logic [M-1:0] rd_adr_a,
  output logic [M-1:0] rd_adr_b,
  output logic [M-2:0] twiddle_adr,
  output logic         we,
  output logic [M-1:0] wr_adr_a,
  output logic [M-1:0] wr_adr_b,
  output logic         res_bank
`ifdef FFT_CTRL_CYCLES_EN
  ,
  output logic [15:0]  cycles
`endif
);

  localparam int unsigned N    = 2 ** M;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned BW   = M - 1;
  localparam int unsigned SW   = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned DW   = (LAT > 1) ? $clog2(LAT) : 1;

  fft_state_e    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          bank_q, bank_d;
  logic          accept;

  logic          busy_d, done_d, rd_vld_d, rd_vld, res_d;
  logic [M-1:0]  rd_a_d, rd_b_d;
  logic [BW-1:0] tw_d;
  logic [31:0]   tw_mask;

  // Start is refused while the done pulse is still on the output.
  assign accept = (state_q == IDLE) && start && !done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
          bank_d  = 1'b0;
        end
      end
      RUN: begin
        b_d = b_q + BW'(1);
        if (b_q == BW'(HALF - 1)) begin
          state_d = DRAIN;
          b_d     = '0;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DW'(LAT - 1)) begin
          if (s_q == SW'(M - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
            b_d     = '0;
            bank_d  = ~bank_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-side values for the next cycle; addresses are zero outside RUN.
  always_comb begin
    busy_d   = (state_q == RUN) || (state_q == DRAIN);
    done_d   = (state_q == DONE);
    rd_vld_d = 1'b0;
    rd_a_d   = '0;
    rd_b_d   = '0;
    tw_d     = '0;
    tw_mask  = '0;
    res_d    = res_bank;
    if (state_q == RUN) begin
      rd_vld_d = 1'b1;
      rd_a_d   = M'(rotl(32'({b_q, 1'b0}), M, 32'(s_q)));
      rd_b_d   = M'(rotl(32'({b_q, 1'b1}), M, 32'(s_q)));
      tw_mask  = ~((32'(1) << (BW - 32'(s_q))) - 32'(1));
      tw_d     = b_q & BW'(tw_mask);
    end
    if ((state_q == DRAIN) && (state_d == DONE)) res_d = ~bank_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_bank     <= 1'b0;
      rd_vld      <= 1'b0;
      rd_adr_a    <= '0;
      rd_adr_b    <= '0;
      twiddle_adr <= '0;
      res_bank    <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      rd_bank     <= bank_q;
      rd_vld      <= rd_vld_d;
      rd_adr_a    <= rd_a_d;
      rd_adr_b    <= rd_b_d;
      twiddle_adr <= tw_d;
      res_bank    <= res_d;
    end
  end

  fft_adr_delay #(
    .LAT(LAT),
    .AW (M)
  ) u_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .d_vld  (rd_vld),
    .d_a    (rd_adr_a),
    .d_b    (rd_adr_b),
    .q_vld  (we),
    .q_a    (wr_adr_a),
    .q_b    (wr_adr_b)
  );

`ifdef FFT_CTRL_CYCLES_EN
  logic [15:0] cnt_q, cnt_d, cycles_d;

  // Saturating clock count from acceptance; published in the DONE cycle.
  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == RUN) || (state_q == DRAIN)) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
    if (state_q == DONE) cycles_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      cycles <= '0;
    end else begin
      cnt_q  <= cnt_d;
      cycles <= cycles_d;
    end
  end
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl at M=4, LAT=2: per-cycle expected output vectors
// and expected writes are queued at start and checked by an independent monitor.
module tb_fft_ctrl;

  localparam int unsigned M   = 4;
  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_bank, we, res_bank;
  logic [3:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [2:0] twiddle_adr;
`ifdef FFT_CTRL_CYCLES_EN
  logic [15:0] cycles;
`endif

  fft_ctrl #(.M(M), .LAT(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_bank    (rd_bank),
    .rd_adr_a   (rd_adr_a),
    .rd_adr_b   (rd_adr_b),
    .twiddle_adr(twiddle_adr),
    .we         (we),
    .wr_adr_a   (wr_adr_a),
    .wr_adr_b   (wr_adr_b),
    .res_bank   (res_bank)
`ifdef FFT_CTRL_CYCLES_EN
    ,
    .cycles     (cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_bank;
    logic       we;
    logic [3:0] rd_a;
    logic [3:0] rd_b;
    logic [2:0] tw;
    logic [3:0] wr_a;
    logic [3:0] wr_b;
  } vec_t;

  typedef struct {
    vec_t v;
    int   tag;
  } ent_t;

  ent_t       exp_q[$];
  logic [8:0] wq[$];
  int         total = 0;
  int         bad = 0;
  int         wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // t = cycles after the start edge; 10 cycles per stage, reads in the first 8.
  function automatic bit rd_valid(input int t);
    return (t >= 1) && (t <= 40) && (((t - 1) % 10) < 8);
  endfunction

  function automatic logic [10:0] rd_at(input int t);
    int unsigned s, b;
    logic [3:0]  a, bb;
    logic [2:0]  tw;
    if (!rd_valid(t)) return '0;
    s  = (t - 1) / 10;
    b  = (t - 1) % 10;
    a  = 4'(fft_pkg::rotl(2 * b, 4, s));
    bb = 4'(fft_pkg::rotl(2 * b + 1, 4, s));
    tw = 3'(b) & ~3'((32'd1 << (3 - s)) - 32'd1);
    return {a, bb, tw};
  endfunction

  function automatic vec_t model_at(input int t, input logic prev_bank);
    vec_t        v;
    logic [10:0] r, w;
    v         = '0;
    r         = rd_at(t);
    w         = rd_at(t - 2);
    v.busy    = (t >= 1) && (t <= 40);
    v.done    = (t == 41);
    v.rd_bank = (t <= 0) ? prev_bank : (t >= 41) ? 1'b1 : 1'(((t - 1) / 10) % 2);
    v.we      = rd_valid(t - 2);
    v.rd_a    = r[10:7];
    v.rd_b    = r[6:3];
    v.tw      = r[2:0];
    v.wr_a    = w[10:7];
    v.wr_b    = w[6:3];
    return v;
  endfunction

  task automatic push_timeline(input int last, input logic prev_bank);
    for (int t = -1; t <= last; t++) begin
      ent_t e;
      e.v   = model_at(t, prev_bank);
      e.tag = (t == 4) ? 1 : (t == 14) ? 2 : (t == 16) ? 3 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_writes();
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        logic [10:0] r;
        r = rd_at(1 + 10 * s + b);
        wq.push_back({r[10:3], ~1'(s % 2)});
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.v   = '0;
      e.tag = 0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    ent_t       e;
    vec_t       act;
    logic [8:0] w;
    act = {busy, done, rd_bank, we, rd_adr_a, rd_adr_b, twiddle_adr, wr_adr_a, wr_adr_b};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_vector", 32'(act), 32'(e.v));
      case (e.tag)
        1: check("s0_b3_adr", 32'({rd_adr_a, rd_adr_b, twiddle_adr}), 32'({4'd6, 4'd7, 3'd0}));
        2: check("s1_b3_adr", 32'({rd_adr_a, rd_adr_b, twiddle_adr}), 32'({4'd12, 4'd14, 3'd0}));
        3: check("s1_b5_adr", 32'({rd_adr_a, rd_adr_b, twiddle_adr}), 32'({4'd5, 4'd7, 3'd4}));
        default: ;
      endcase
    end
    if (we) begin
      wcnt++;
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: got we=1 adr %0h/%0h want no write at %0t",
                 wr_adr_a, wr_adr_b, $time);
      end else begin
        w = wq.pop_front();
        check("write", 32'({wr_adr_a, wr_adr_b, ~rd_bank}), 32'(w));
      end
    end
  end

  // One transform; abort_at>0 drops reset at that cycle, poke adds ignored starts.
  task automatic run(input int abort_at, input bit poke, input logic prev_bank);
    int lat;
    lat = 0;
    @(posedge clk);
    #2;
    start = 1'b1;
    wcnt  = 0;
    push_timeline((abort_at > 0) ? abort_at - 1 : 43, prev_bank);
    push_writes();
    @(posedge clk);
    #2;
    start = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      @(posedge clk);
      #2;
      if (done && lat == 0) lat = c;
      start = poke && (c == 4 || c == 41);
      if (abort_at > 0 && c == abort_at) begin
        reset_n = 1'b0;
        wq.delete();
        push_idle(3);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        return;
      end
    end
    check("done_latency", 32'(lat), 32'd41);
    check("we_count", 32'(wcnt), 32'd32);
    check("res_bank", 32'(res_bank), 32'd0);
    check("writes_left", 32'(wq.size()), 32'd0);
    check("vectors_left", 32'(exp_q.size()), 32'd0);
`ifdef FFT_CTRL_CYCLES_EN
    check("cycles", 32'(cycles), 32'd41);
`endif
  endtask

  initial begin
    push_idle(3);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    run(0, 1'b0, 1'b0);
    run(0, 1'b1, 1'b1);
    run(29, 1'b0, 1'b1);
    run(0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
